// File: rtl/stepper_phase_seq_pkg.sv
// stepper_phase_seq_pkg: shared phase table, state encoding and index stepping helper
package stepper_phase_seq_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam logic STEP_FULL = 1'b1;
  localparam logic STEP_HALF = 1'b0;
  localparam logic [3:0] PHASE_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001
  };
  function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic mode, input logic fwd);
    logic [2:0] d;
    d = (mode == STEP_FULL && idx[0]) ? 3'd2 : 3'd1;
    return fwd ? idx + d : idx - d;
  endfunction
endpackage

// File: rtl/stepper_phase_seq_if.sv
// stepper_phase_seq_if: motion-control command inputs and coil-side outputs of the sequencer
interface stepper_phase_seq_if;
  logic       run;
  logic       step;
  logic       dir;
  logic [3:0] coils;
  logic       step_pulse;
  logic [7:0] pos;
  logic       busy;
  modport master (output run, step, dir, input coils, step_pulse, pos, busy);
  modport slave  (input run, step, dir, output coils, step_pulse, pos, busy);
endinterface

// File: rtl/stepper_phase_seq_step_tick_gen.sv
// step_tick_gen: step-rate prescaler, one tick every STEP_DIV enabled cycles (0 acts as 1)
module step_tick_gen #(
  parameter logic [15:0] STEP_DIV = 16'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam logic [15:0] DIV_EFF = (STEP_DIV == 16'd0) ? 16'd1 : STEP_DIV;
  logic [15:0] cnt_q, cnt_d;
  // tick on the last count of the period; clear wins so a fresh run starts from zero
  always_comb begin
    tick  = en && cnt_q == DIV_EFF - 16'd1;
    cnt_d = (clear || tick) ? 16'd0 : en ? cnt_q + 16'd1 : cnt_q;
  end
  // prescaler counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 16'd0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/stepper_phase_seq.sv
// stepper_phase_seq: run/mode/direction to unipolar coil patterns with step pulse and position count
module stepper_phase_seq
  import stepper_phase_seq_pkg::*;
#(
  parameter logic [15:0] STEP_DIV = 16'd1,
  parameter logic        IDLE_OFF = 1'b1
) (
  input logic                clk,
  input logic                rst,
  stepper_phase_seq_if.slave bus
);
  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d, nxt;
  logic [3:0] coils_q, coils_d, idle_coils;
  logic       pulse_q, pulse_d;
  logic [7:0] pos_q, pos_d;
  logic       running, tick;
  assign running = state_q == RUN && bus.run;
  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (!running),
    .en    (running),
    .tick  (tick)
  );
  // next state: run low always wins over a pending tick, so dropping run never advances
  always_comb begin
    nxt        = next_idx(idx_q, bus.step, bus.dir);
    idle_coils = IDLE_OFF ? 4'b0000 : PHASE_TABLE[idx_q];
    state_d    = bus.run ? RUN : IDLE;
    idx_d      = tick ? nxt : idx_q;
    pulse_d    = tick;
    pos_d      = (state_q == IDLE && bus.run) ? 8'd0 : (tick && pos_q != 8'hff) ? pos_q + 8'd1 : pos_q;
    coils_d    = !bus.run ? idle_coils : tick ? PHASE_TABLE[nxt] : state_q == IDLE ? PHASE_TABLE[idx_q] : coils_q;
  end
  // FSM and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      coils_q <= 4'b0000;
      pulse_q <= 1'b0;
      pos_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      coils_q <= coils_d;
      pulse_q <= pulse_d;
      pos_q   <= pos_d;
    end
  end
  assign bus.coils      = coils_q;
  assign bus.step_pulse = pulse_q;
  assign bus.pos        = pos_q;
  assign bus.busy       = state_q == RUN;
endmodule

// File: doc/stepper_phase_seq.md
Name: stepper_phase_seq

Overview:
- Downstream consumer of the quarter-turn counter's move-enable level (run).
- Converts run, step mode (full/half) and direction into 4-bit unipolar coil drive patterns at a programmable step rate.
- Also reports steps taken since run was asserted.
- Sits between the motion-control counters and the coil driver pins; clocked by clk_for_motor.

Parameters:
- STEP_DIV, 16'd1, clk cycles per coil-pattern advance; value 0 is treated as 1.
- IDLE_OFF, 1'b1, 1 = de-energise coils (4'b0000) when not running; 0 = hold the last pattern.

Ports:
- clk  input  1  motor clock (clk_for_motor)
- rst  input  1  asynchronous, active-low reset
- run  input  1  move enable level, driven from quarter_out
- step  input  1  1 = full step (two-phase-on), 0 = half step
- dir  input  1  1 = forward (index increments), 0 = reverse (index decrements)
- coils  output  4  coil drive pattern {A,B,C,D}, registered
- step_pulse  output  1  one-cycle pulse on every index advance
- pos  output  8  advances since the last IDLE->RUN entry; saturates at 255
- busy  output  1  high while state = RUN

Behaviour:
- Reset (rst=0, async): state=IDLE, idx=3'd0, cnt=0, coils=4'b0000, step_pulse=0, pos=0, busy=0.
- Phase table, indexed by idx 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
- Next-index rule:
  - Half step: idx±1.
  - Full step: if idx is odd, idx±2; if idx is even, idx±1 (realigns to the odd/two-phase entries).
  - "+" when dir=1, "-" when dir=0; all arithmetic mod 8, so 7->0 and 0->7 wrap.
- step and dir are sampled only on the advance edge. Mode or direction changes take effect at the next advance with no glitch.
- FSM, 2 states:
  - IDLE, run=1: ->RUN; cnt<=0; pos<=0; busy<=1; coils<=table[idx] (energise at current phase, no advance).
  - IDLE, run=0: stay; coils<=IDLE_OFF ? 0000 : table[idx].
  - RUN, run=1, cnt==STEP_DIV_EFF-1: idx<=next; coils<=table[next]; step_pulse<=1; pos<=pos+1 (saturate at 255); cnt<=0.
  - RUN, run=1, otherwise: cnt<=cnt+1; step_pulse<=0.
  - RUN, run=0: ->IDLE; busy<=0; cnt<=0; step_pulse<=0; coils per the IDLE rule; idx and pos held.
- Latency: first advance occurs STEP_DIV_EFF edges after the edge at which RUN is entered. Successive advances are STEP_DIV_EFF cycles apart.
- step_pulse is never high for more than one consecutive cycle unless STEP_DIV_EFF=1. In that case it stays high every cycle while running.
- run falling on the same edge a step would fire: the step does NOT fire; run=0 has priority.
- run re-asserted later: pos restarts at 0; idx continues from the held value.
- Async reset mid-RUN: immediate return to the reset values above.

Decomposition:
- Shared package (motor_pkg):
  - PHASE_TABLE constant, 8 x 4 bits.
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - STEP_FULL=1'b1 / STEP_HALF=1'b0 constants, shared with the quarter-turn counter.
- Natural sub-module: step_tick_gen.
  - Implements the STEP_DIV prescaler.
  - Inputs: clk, rst, clear, en. Output: tick (one cycle at cnt==STEP_DIV_EFF-1).
  - Parent FSM owns idx, coils, pos and busy.

Test Plan:
- Reset then idle: rst low 2 cycles, run=0 -> coils=0000, busy=0, pos=0, step_pulse=0.
- Half-step forward: STEP_DIV=4, step=0, dir=1, run high 33 cycles
  - coils 1000 on the entry edge, then 1100, 0100, ... at 4-cycle spacing.
  - After 8 advances idx wraps to 0 (1000); pos=8 at cycle 32.
- Full-step reverse: STEP_DIV=1, idx=0, step=1, dir=0
  - First advance -> idx 7 (1001), then 5 (0011), 3 (0110), 1 (1100), 7.
  - step_pulse high every cycle; pos increments each cycle.
- Mode switch mid-run: half-step forward to idx=2, then set step=1 -> next idx=3 (0110), then 5 (0011).
- run drop coincident with tick: STEP_DIV=2, run falls on the tick edge
  - No advance; idx and pos unchanged.
  - IDLE_OFF=1 -> coils=0000; IDLE_OFF=0 -> coils hold the last pattern.
- Saturation and async reset:
  - STEP_DIV=1, run held 300 cycles -> pos stays 255.
  - Assert rst mid-run -> all outputs return to reset values without a clock edge.
